// File: rtl/mem_access_sequencer.sv
// Load/store sequencer between the control FSM and a 64-bit data memory port.
// Optional MISALIGN_TRAP_EN: misaligned accesses complete at once and pulse misalign.
module mem_access_sequencer #(
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] instr,
  input  logic [63:0] addr,
  input  logic [63:0] store_data,
  input  logic [63:0] mem_rdata,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic        mem_wr,
  output logic [63:0] load_data,
  output logic        rd_we,
  output logic        busy,
`ifdef MISALIGN_TRAP_EN
  output logic        misalign,
`endif
  output logic        done
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WRITE, DONE} state_t;

  localparam logic [6:0] OP_LOAD  = 7'd3;
  localparam logic [6:0] OP_STORE = 7'd35;

  state_t      state_reg;
  logic [2:0]  f3_reg;
  logic        is_load_reg;
  logic [63:0] sdata_reg;
  logic [2:0]  cnt_reg;
  logic [63:0] load_ext;
  logic [63:0] merged;
  logic        misalign_hit;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       unused_bits;
  assign opcode      = instr[6:0];
  assign funct3      = instr[14:12];
  assign unused_bits = ^{instr[31:15], instr[11:7]};

  always_comb begin
    case (f3_reg)
      3'd0:    load_ext = {{56{mem_rdata[7]}}, mem_rdata[7:0]};
      3'd1:    load_ext = {{48{mem_rdata[15]}}, mem_rdata[15:0]};
      3'd2:    load_ext = {{32{mem_rdata[31]}}, mem_rdata[31:0]};
      3'd4:    load_ext = {56'd0, mem_rdata[7:0]};
      3'd5:    load_ext = {48'd0, mem_rdata[15:0]};
      3'd6:    load_ext = {32'd0, mem_rdata[31:0]};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    case (f3_reg)
      3'd0:    merged = {mem_rdata[63:8], sdata_reg[7:0]};
      3'd1:    merged = {mem_rdata[63:16], sdata_reg[15:0]};
      3'd2:    merged = {mem_rdata[63:32], sdata_reg[31:0]};
      default: merged = sdata_reg;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  // Checked against the live inputs because the decision is made on the accepting edge.
  always_comb begin
    misalign_hit = 1'b0;
    if (opcode == OP_LOAD || opcode == OP_STORE) begin
      case (funct3)
        3'd1:    misalign_hit = addr[0];
        3'd2:    misalign_hit = |addr[1:0];
        3'd3:    misalign_hit = |addr[2:0];
        3'd5:    misalign_hit = (opcode == OP_LOAD) && addr[0];
        3'd6:    misalign_hit = (opcode == OP_LOAD) && (|addr[1:0]);
        default: misalign_hit = 1'b0;
      endcase
    end
  end
`else
  assign misalign_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      f3_reg      <= 3'd0;
      is_load_reg <= 1'b0;
      sdata_reg   <= 64'd0;
      cnt_reg     <= 3'd0;
      mem_addr    <= 64'd0;
      mem_wdata   <= 64'd0;
      mem_wr      <= 1'b0;
      load_data   <= 64'd0;
      rd_we       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign    <= 1'b0;
`endif
    end else begin
      mem_wr <= 1'b0;
      rd_we  <= 1'b0;
      done   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          if (start) begin
            f3_reg      <= funct3;
            is_load_reg <= (opcode == OP_LOAD);
            sdata_reg   <= store_data;
            mem_addr    <= addr;
            cnt_reg     <= 3'(MEM_LAT - 1);
            busy        <= 1'b1;
            if (misalign_hit) begin
              state_reg <= DONE;
              done      <= 1'b1;
`ifdef MISALIGN_TRAP_EN
              misalign  <= 1'b1;
`endif
            end else if (opcode == OP_STORE && funct3 == 3'd3) begin
              state_reg <= WRITE;
              mem_wdata <= store_data;
              mem_wr    <= 1'b1;
            end else if (opcode == OP_LOAD || opcode == OP_STORE) begin
              state_reg <= RD_WAIT;
            end else begin
              state_reg <= DONE;
              done      <= 1'b1;
            end
          end
        end
        RD_WAIT: begin
          if (cnt_reg == 3'd0) begin
            if (is_load_reg) begin
              load_data <= load_ext;
              rd_we     <= 1'b1;
              done      <= 1'b1;
              state_reg <= DONE;
            end else begin
              mem_wdata <= merged;
              mem_wr    <= 1'b1;
              state_reg <= WRITE;
            end
          end else begin
            cnt_reg <= cnt_reg - 3'd1;
          end
        end
        WRITE: begin
          done      <= 1'b1;
          state_reg <= DONE;
        end
        default: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Randomized and directed checks of mem_access_sequencer against a byte-level reference model.
module tb_mem_access_sequencer;
  localparam int LAT = 2;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] instr;
  logic [63:0] addr, store_data, mem_rdata;
  logic [63:0] mem_addr, mem_wdata, load_data;
  logic        mem_wr, rd_we, busy, done;
`ifdef MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int total = 0;
  int bad   = 0;
  logic [63:0] m_ld = 64'd0;

  always #5 clk = ~clk;

  mem_access_sequencer #(.MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .instr(instr), .addr(addr),
    .store_data(store_data), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wr(mem_wr), .load_data(load_data),
    .rd_we(rd_we), .busy(busy),
`ifdef MISALIGN_TRAP_EN
    .misalign(misalign),
`endif
    .done(done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] byte_mask(input int n);
    return (n >= 8) ? {64{1'b1}} : ((64'd1 << (8 * n)) - 64'd1);
  endfunction

  function automatic int access_size(input logic [6:0] op, input logic [2:0] f3);
    if (op == 7'd3) begin
      case (f3)
        3'd1, 3'd5: return 2;
        3'd2, 3'd6: return 4;
        3'd3:       return 8;
        default:    return 1;
      endcase
    end
    case (f3)
      3'd1:    return 2;
      3'd2:    return 4;
      3'd3:    return 8;
      default: return 1;
    endcase
  endfunction

  function automatic logic [63:0] model_load(input logic [2:0] f3, input logic [63:0] d);
    int n;
    bit sgn;
    logic [63:0] m, v;
    n   = (f3 == 3'd3 || f3 == 3'd7) ? 8 : (1 << f3[1:0]);
    sgn = (f3 < 3'd3);
    m   = byte_mask(n);
    v   = d & m;
    if (sgn && n < 8 && ((v >> (8 * n - 1)) & 64'd1) == 64'd1) v = v | ~m;
    return v;
  endfunction

  function automatic logic [63:0] model_merge(input logic [2:0] f3, input logic [63:0] rd,
                                              input logic [63:0] sd);
    logic [63:0] m;
    m = (f3 < 3'd3) ? byte_mask(1 << f3[1:0]) : {64{1'b1}};
    return (rd & ~m) | (sd & m);
  endfunction

  task automatic do_op(input logic [6:0] op, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] sdv, input logic [63:0] rdv, input bit poke);
    logic [31:0] r;
    logic [63:0] wd, wa, ld;
    int cyc, wrs, rdwes, busy_low, exp_lat, exp_wrs;
    bit got_done, rdwe_done, is_ld, is_st, trap, mis_done;
    r = $urandom();
    wd = 64'd0; wa = 64'd0; ld = 64'd0;
    cyc = 0; wrs = 0; rdwes = 0; busy_low = 0;
    got_done = 0; rdwe_done = 0; mis_done = 0;
    is_ld = (op == 7'd3);
    is_st = (op == 7'd35);
    trap  = TRAP && (is_ld || is_st) && ((a % 64'(access_size(op, f3))) != 64'd0);
    if (trap || !(is_ld || is_st)) exp_lat = 1;
    else if (is_ld)                exp_lat = LAT + 1;
    else if (f3 == 3'd3)           exp_lat = 2;
    else                           exp_lat = LAT + 2;
    exp_wrs = (is_st && !trap) ? 1 : 0;

    @(negedge clk);
    start = 1'b1; instr = {r[31:15], f3, r[11:7], op}; addr = a;
    store_data = sdv; mem_rdata = rdv;
    while (!got_done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      start      = poke && (cyc == 1);
      instr      = $urandom();
      addr       = {$urandom(), $urandom()};
      store_data = {$urandom(), $urandom()};
      if (!busy) busy_low++;
      if (mem_wr) begin wrs++; wd = mem_wdata; wa = mem_addr; end
      if (rd_we) rdwes++;
      if (done) begin
        got_done = 1; ld = load_data; rdwe_done = rd_we;
`ifdef MISALIGN_TRAP_EN
        mis_done = misalign;
`endif
      end
    end
    @(negedge clk);
    start = 1'b0;

    if (is_ld && !trap) m_ld = model_load(f3, rdv);
    $display("op=%02h f3=%0d addr=%h sd=%h rd=%h lat=%0d wr=%0d wd=%h ld=%h",
             op, f3, a, sdv, rdv, cyc, wrs, wd, ld);
    chk("done_seen", 64'(got_done), 64'd1);
    chk("latency", 64'(cyc), 64'(exp_lat));
    chk("busy_during", 64'(busy_low), 64'd0);
    chk("mem_wr_count", 64'(wrs), 64'(exp_wrs));
    chk("rd_we_count", 64'(rdwes), (is_ld && !trap) ? 64'd1 : 64'd0);
    chk("rd_we_at_done", 64'(rdwe_done), (is_ld && !trap) ? 64'd1 : 64'd0);
    chk("load_data", ld, m_ld);
    chk("misalign", 64'(mis_done), 64'(trap));
    if (exp_wrs == 1) begin
      chk("mem_wdata", wd, (f3 == 3'd3) ? sdv : model_merge(f3, rdv, sdv));
      chk("mem_addr", wa, a);
    end
    chk("busy_after", 64'(busy), 64'd0);
  endtask

  initial begin
    int wrs, dns;
    logic [6:0] op;
    logic [2:0] f3;
    logic [63:0] a;
    reset = 1'b1; start = 1'b0; instr = 32'd0; addr = 64'd0;
    store_data = 64'd0; mem_rdata = 64'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_mem_wr", 64'(mem_wr), 64'd0);
    chk("rst_rd_we", 64'(rd_we), 64'd0);
    chk("rst_load_data", load_data, 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);

    do_op(7'd3,  3'd0, 64'h100, 64'd0, 64'h00000000_000000F0, 0);
    do_op(7'd3,  3'd6, 64'h100, 64'd0, 64'h12345678_9ABCDEF0, 0);
    do_op(7'd3,  3'd2, 64'h100, 64'd0, 64'h12345678_9ABCDEF0, 1);
    do_op(7'd35, 3'd0, 64'h101, 64'hAA, 64'h11223344_55667788, 0);
    do_op(7'd35, 3'd3, 64'h200, 64'hDEADBEEF_CAFEF00D, 64'h5555, 1);
    do_op(7'd51, 3'd0, 64'h300, 64'h1234, 64'hFFFF, 1);
    do_op(7'd3,  3'd1, 64'h102, 64'd0, 64'h0000_0000_0000_8001, 0);
    do_op(7'd3,  3'd5, 64'h102, 64'd0, 64'h0000_0000_0000_8001, 0);
    do_op(7'd3,  3'd3, 64'h108, 64'd0, 64'h8000_0000_0000_0001, 0);
    do_op(7'd3,  3'd7, 64'h108, 64'd0, 64'hF0E1_D2C3_B4A5_9687, 0);
    do_op(7'd35, 3'd1, 64'h102, 64'hBEEF, 64'h11223344_55667788, 1);
    do_op(7'd35, 3'd2, 64'h104, 64'hCAFEF00D, 64'h11223344_55667788, 0);
`ifdef MISALIGN_TRAP_EN
    do_op(7'd3,  3'd2, 64'h1002, 64'd0, 64'h12345678_9ABCDEF0, 0);
    do_op(7'd35, 3'd3, 64'h1004, 64'h77, 64'h1, 0);
`endif

    // sb interrupted by reset while waiting on the read; a retrigger is attempted first
    @(negedge clk);
    start = 1'b1; instr = {17'd0, 3'd0, 5'd0, 7'd35}; addr = 64'h440;
    store_data = 64'hAB; mem_rdata = 64'h1111_2222_3333_4444;
    @(negedge clk);
    start = 1'b1; instr = {17'd0, 3'd3, 5'd0, 7'd35};
    @(negedge clk);
    start = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_ld = 64'd0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_mem_wr", 64'(mem_wr), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_mem_addr", mem_addr, 64'd0);
    wrs = 0; dns = 0;
    repeat (8) begin
      @(negedge clk);
      if (mem_wr) wrs++;
      if (done) dns++;
    end
    $display("reset mid-op: writes=%0d dones=%0d", wrs, dns);
    chk("midrst_no_write", 64'(wrs), 64'd0);
    chk("midrst_no_done", 64'(dns), 64'd0);

    repeat (40) begin
      case ($urandom_range(0, 3))
        0, 1:    op = 7'd3;
        2:       op = 7'd35;
        default: op = 7'($urandom_range(0, 127));
      endcase
      f3 = 3'($urandom_range(0, 7));
      a  = {$urandom(), $urandom()};
      if ($urandom_range(0, 1) == 0) a[2:0] = 3'd0;
      do_op(op, f3, a, {$urandom(), $urandom()}, {$urandom(), $urandom()},
            ($urandom_range(0, 1) == 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
